// File: rtl/cv32e40px_core_v_xif_pkg.sv
// Shared types for the coprocessor side of the CORE-V-XIF offload interface.
// Queue entries carry a fixed-width ID field so the entry type stays independent of the module parameters.
package cv32e40px_core_v_xif_pkg;

    localparam int unsigned X_ID_MAX_WIDTH = 8;

    typedef struct packed {
        logic [X_ID_MAX_WIDTH-1:0] id;
        logic [4:0]                rd;
        logic                      we;
        logic [9:0]                op;
        logic [1:0][31:0]          rs;
        logic                      committed;
        logic                      killed;
    } x_coproc_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESULT
    } x_coproc_state_e;

    // Execution-unit operation code: {funct7, funct3}
    function automatic logic [9:0] xif_op(input logic [31:0] instr);
        return {instr[31:25], instr[14:12]};
    endfunction

endpackage

// File: rtl/cv32e40px_x_instr_queue.sv
// In-order instruction FIFO whose entries can have their commit/kill flag set by transaction ID.
// Entries are registers rather than RAM because every entry is compared against the commit ID in parallel.
module cv32e40px_x_instr_queue
    import cv32e40px_core_v_xif_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      push_i,
    input  x_coproc_entry_t           push_entry_i,
    input  logic                      pop_i,
    input  logic                      upd_valid_i,
    input  logic [X_ID_MAX_WIDTH-1:0] upd_id_i,
    input  logic                      upd_kill_i,
    output x_coproc_entry_t           head_o,
    output logic                      full_o,
    output logic                      empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]     r_wptr;
    logic [AW:0]     r_rptr;
    x_coproc_entry_t w_entries [DEPTH];
    x_coproc_entry_t w_push_entry;
    logic            w_upd_new;

    // A commit may target the instruction being enqueued in the same cycle
    assign w_upd_new = upd_valid_i && (upd_id_i == push_entry_i.id);

    always_comb begin
        w_push_entry           = push_entry_i;
        w_push_entry.committed = w_upd_new && !upd_kill_i;
        w_push_entry.killed    = w_upd_new && upd_kill_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (push_i) r_wptr <= r_wptr + (AW+1)'(1);
            if (pop_i)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic            r_valid;
            x_coproc_entry_t r_entry;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_valid <= 1'b0;
                    r_entry <= '0;
                end else if (push_i && (r_wptr[AW-1:0] == AW'(gi))) begin
                    r_valid <= 1'b1;
                    r_entry <= w_push_entry;
                end else begin
                    if (pop_i && (r_rptr[AW-1:0] == AW'(gi))) r_valid <= 1'b0;
                    if (upd_valid_i && r_valid && (r_entry.id == upd_id_i)) begin
                        if (upd_kill_i) r_entry.killed    <= 1'b1;
                        else            r_entry.committed <= 1'b1;
                    end
                end
            end

            assign w_entries[gi] = r_entry;
        end
    endgenerate

    assign head_o  = w_entries[r_rptr[AW-1:0]];
    assign empty_o = (r_wptr == r_rptr);
    assign full_o  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

endmodule

// File: rtl/cv32e40px_x_coproc_if.sv
// Coprocessor responder for CORE-V-XIF: pre-decodes offloaded custom instructions, holds them until
// commit/kill, runs committed ones through a single-issue execution unit and returns the writeback.
module cv32e40px_x_coproc_if
    import cv32e40px_core_v_xif_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter logic [6:0]  OPCODE     = 7'h0B,
    parameter int unsigned X_ID_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  issue_valid_i,
    output logic                  issue_ready_o,
    input  logic [31:0]           issue_req_instr_i,
    input  logic [1:0][31:0]      issue_req_rs_i,
    input  logic [1:0]            issue_req_rs_valid_i,
    input  logic [X_ID_WIDTH-1:0] issue_req_id_i,
    output logic                  issue_resp_accept_o,
    output logic                  issue_resp_writeback_o,
    output logic                  issue_resp_dualread_o,
    output logic                  issue_resp_loadstore_o,
    input  logic                  commit_valid_i,
    input  logic [X_ID_WIDTH-1:0] commit_id_i,
    input  logic                  commit_kill_i,
    output logic                  exe_valid_o,
    input  logic                  exe_ready_i,
    output logic [9:0]            exe_op_o,
    output logic [1:0][31:0]      exe_rs_o,
    input  logic                  exe_done_i,
    input  logic [31:0]           exe_data_i,
    output logic                  result_valid_o,
    input  logic                  result_ready_i,
    output logic [X_ID_WIDTH-1:0] result_id_o,
    output logic [4:0]            result_rd_o,
    output logic                  result_we_o,
    output logic [31:0]           result_data_o
);

    logic            w_accept;
    logic            w_writeback;
    logic            w_handshake;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    x_coproc_entry_t w_push_entry;
    x_coproc_entry_t w_head;
    x_coproc_state_e r_state;
    x_coproc_state_e w_state_next;

    logic [X_ID_WIDTH-1:0] r_exec_id;
    logic [4:0]            r_exec_rd;
    logic                  r_exec_we;
    logic                  r_result_valid;
    logic [X_ID_WIDTH-1:0] r_result_id;
    logic [4:0]            r_result_rd;
    logic                  r_result_we;
    logic [31:0]           r_result_data;

    assign w_accept    = (issue_req_instr_i[6:0] == OPCODE);
    assign w_writeback = w_accept && (issue_req_instr_i[11:7] != 5'd0);

    // Foreign instructions are always taken so the core can move on to the next coprocessor
    assign issue_ready_o = w_accept ? (!w_full && (&issue_req_rs_valid_i)) : 1'b1;
    assign w_handshake   = issue_valid_i && issue_ready_o;
    assign w_push        = w_handshake && w_accept;

    assign issue_resp_accept_o    = w_handshake && w_accept;
    assign issue_resp_writeback_o = w_handshake && w_writeback;
    assign issue_resp_dualread_o  = 1'b0;
    assign issue_resp_loadstore_o = 1'b0;

    always_comb begin
        w_push_entry    = '0;
        w_push_entry.id = X_ID_MAX_WIDTH'(issue_req_id_i);
        w_push_entry.rd = issue_req_instr_i[11:7];
        w_push_entry.we = w_writeback;
        w_push_entry.op = xif_op(issue_req_instr_i);
        w_push_entry.rs = issue_req_rs_i;
    end

    cv32e40px_x_instr_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_i       (w_push),
        .push_entry_i (w_push_entry),
        .pop_i        (w_pop),
        .upd_valid_i  (commit_valid_i),
        .upd_id_i     (X_ID_MAX_WIDTH'(commit_id_i)),
        .upd_kill_i   (commit_kill_i),
        .head_o       (w_head),
        .full_o       (w_full),
        .empty_o      (w_empty)
    );

    assign exe_op_o = w_head.op;
    assign exe_rs_o = w_head.rs;

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        exe_valid_o  = 1'b0;
        case (r_state)
            IDLE: begin
                // Killed heads are retired silently, one per cycle
                if (!w_empty && w_head.killed) begin
                    w_pop = 1'b1;
                end else if (!w_empty && w_head.committed) begin
                    exe_valid_o = 1'b1;
                    if (exe_ready_i) begin
                        w_pop        = 1'b1;
                        w_state_next = EXEC;
                    end
                end
            end
            EXEC:    if (exe_done_i)     w_state_next = RESULT;
            RESULT:  if (result_ready_i) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state        <= IDLE;
            r_exec_id      <= '0;
            r_exec_rd      <= '0;
            r_exec_we      <= 1'b0;
            r_result_valid <= 1'b0;
            r_result_id    <= '0;
            r_result_rd    <= '0;
            r_result_we    <= 1'b0;
            r_result_data  <= '0;
        end else begin
            r_state <= w_state_next;
            if (exe_valid_o && exe_ready_i) begin
                r_exec_id <= w_head.id[X_ID_WIDTH-1:0];
                r_exec_rd <= w_head.rd;
                r_exec_we <= w_head.we;
            end
            if (r_state == EXEC && exe_done_i) begin
                r_result_valid <= 1'b1;
                r_result_id    <= r_exec_id;
                r_result_rd    <= r_exec_rd;
                r_result_we    <= r_exec_we;
                r_result_data  <= exe_data_i;
            end else if (r_state == RESULT && result_ready_i) begin
                r_result_valid <= 1'b0;
            end
        end
    end

    assign result_valid_o = r_result_valid;
    assign result_id_o    = r_result_id;
    assign result_rd_o    = r_result_rd;
    assign result_we_o    = r_result_we;
    assign result_data_o  = r_result_data;

endmodule

// File: tb/tb_cv32e40px_x_coproc_if.sv
// Bench for the XIF coprocessor responder: directed scenarios plus a randomized stream
// checked against an in-order issue/commit/result model.
module tb_cv32e40px_x_coproc_if;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             issue_valid_i;
    logic             issue_ready_o;
    logic [31:0]      issue_req_instr_i;
    logic [1:0][31:0] issue_req_rs_i;
    logic [1:0]       issue_req_rs_valid_i;
    logic [3:0]       issue_req_id_i;
    logic             issue_resp_accept_o;
    logic             issue_resp_writeback_o;
    logic             issue_resp_dualread_o;
    logic             issue_resp_loadstore_o;
    logic             commit_valid_i;
    logic [3:0]       commit_id_i;
    logic             commit_kill_i;
    logic             exe_valid_o;
    logic             exe_ready_i;
    logic [9:0]       exe_op_o;
    logic [1:0][31:0] exe_rs_o;
    logic             exe_done_i;
    logic [31:0]      exe_data_i;
    logic             result_valid_o;
    logic             result_ready_i;
    logic [3:0]       result_id_o;
    logic [4:0]       result_rd_o;
    logic             result_we_o;
    logic [31:0]      result_data_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]       id;
        logic [4:0]       rd;
        logic             we;
        logic [9:0]       op;
        logic [1:0][31:0] rs;
        bit               decided;
        bit               kill;
    } item_t;

    typedef struct {
        logic [3:0]  id;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
    } res_t;

    always #5 clk_i = ~clk_i;

    cv32e40px_x_coproc_if #(
        .DEPTH(4), .OPCODE(7'h0B), .X_ID_WIDTH(4)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_req_instr_i(issue_req_instr_i), .issue_req_rs_i(issue_req_rs_i),
        .issue_req_rs_valid_i(issue_req_rs_valid_i), .issue_req_id_i(issue_req_id_i),
        .issue_resp_accept_o(issue_resp_accept_o), .issue_resp_writeback_o(issue_resp_writeback_o),
        .issue_resp_dualread_o(issue_resp_dualread_o), .issue_resp_loadstore_o(issue_resp_loadstore_o),
        .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
        .exe_valid_o(exe_valid_o), .exe_ready_i(exe_ready_i), .exe_op_o(exe_op_o), .exe_rs_o(exe_rs_o),
        .exe_done_i(exe_done_i), .exe_data_i(exe_data_i),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .result_id_o(result_id_o), .result_rd_o(result_rd_o), .result_we_o(result_we_o),
        .result_data_o(result_data_o)
    );

    function automatic logic [31:0] mk_instr(input logic [6:0] opc, input logic [4:0] rd,
                                             input logic [2:0] f3, input logic [6:0] f7);
        logic [9:0] regs;
        regs = 10'($urandom);
        return {f7, regs, f3, rd, opc};
    endfunction

    // Arbitrary function standing in for the execution unit
    function automatic logic [31:0] exe_model(input logic [9:0] op, input logic [1:0][31:0] rs);
        return (rs[0] + rs[1]) ^ {22'd0, op};
    endfunction

    task automatic idle_inputs();
        issue_valid_i        = 1'b0;
        issue_req_instr_i    = '0;
        issue_req_rs_i       = '0;
        issue_req_rs_valid_i = 2'b11;
        issue_req_id_i       = '0;
        commit_valid_i       = 1'b0;
        commit_id_i          = '0;
        commit_kill_i        = 1'b0;
        exe_ready_i          = 1'b0;
        exe_done_i           = 1'b0;
        exe_data_i           = '0;
        result_ready_i       = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        idle_inputs();
        tick();
        rst_i = 1'b0;
        tick();
    endtask

    task automatic issue_one(input logic [31:0] instr, input logic [3:0] id,
                             input logic [1:0][31:0] rs, input bit commit);
        issue_valid_i = 1'b1; issue_req_instr_i = instr; issue_req_id_i = id;
        issue_req_rs_i = rs; issue_req_rs_valid_i = 2'b11;
        commit_valid_i = commit; commit_id_i = id; commit_kill_i = 1'b0;
        #1;
        checks++;
        if (issue_ready_o !== 1'b1) begin
            failures++; $display("FAIL issue_ready id=%0d got=%0b exp=1", id, issue_ready_o);
        end
        tick();
        issue_valid_i = 1'b0; commit_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        idle_inputs();
        issue_req_instr_i = 32'h0000_208B;
        tick(); tick();
        checks++;
        if ({exe_valid_o, result_valid_o, result_id_o, result_rd_o, result_we_o, result_data_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got exe_valid=%0b result_valid=%0b id=%0d rd=%0d we=%0b data=%h exp all 0",
                     exe_valid_o, result_valid_o, result_id_o, result_rd_o, result_we_o, result_data_o);
        end
        checks++;
        if (issue_ready_o !== 1'b1) begin
            failures++; $display("FAIL reset_issue_ready got=%0b exp=1", issue_ready_o);
        end
        rst_i = 1'b0;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_basic();
        logic [1:0][31:0] rs;
        rs = {$urandom, $urandom};
        issue_valid_i = 1'b1; issue_req_instr_i = 32'h0000_208B; issue_req_id_i = 4'd3;
        issue_req_rs_i = rs; issue_req_rs_valid_i = 2'b11;
        commit_valid_i = 1'b1; commit_id_i = 4'd3; commit_kill_i = 1'b0;
        #1;
        checks++;
        if ({issue_ready_o, issue_resp_accept_o, issue_resp_writeback_o, issue_resp_dualread_o, issue_resp_loadstore_o} !== 5'b11100) begin
            failures++;
            $display("FAIL basic_issue_resp got ready=%0b acc=%0b wb=%0b dr=%0b ls=%0b exp 1 1 1 0 0", issue_ready_o,
                     issue_resp_accept_o, issue_resp_writeback_o, issue_resp_dualread_o, issue_resp_loadstore_o);
        end
        tick();
        issue_valid_i = 1'b0; commit_valid_i = 1'b0; exe_ready_i = 1'b1;
        #1;
        checks++;
        if (exe_valid_o !== 1'b1 || exe_op_o !== 10'h002 || exe_rs_o !== rs) begin
            failures++;
            $display("FAIL basic_exe got valid=%0b op=%h rs=%h exp valid=1 op=002 rs=%h", exe_valid_o, exe_op_o, exe_rs_o, rs);
        end
        tick();
        exe_ready_i = 1'b0;
        #1;
        checks++;
        if (exe_valid_o !== 1'b0) begin
            failures++; $display("FAIL basic_exe_busy got exe_valid=%0b exp=0", exe_valid_o);
        end
        tick();
        exe_done_i = 1'b1; exe_data_i = 32'h0000_CAFE;
        tick();
        exe_done_i = 1'b0;
        #1;
        checks++;
        if ({result_valid_o, result_id_o, result_rd_o, result_we_o, result_data_o} !== {1'b1, 4'd3, 5'd1, 1'b1, 32'h0000_CAFE}) begin
            failures++;
            $display("FAIL basic_result got valid=%0b id=%0d rd=%0d we=%0b data=%h exp 1 3 1 1 0000cafe",
                     result_valid_o, result_id_o, result_rd_o, result_we_o, result_data_o);
        end
        result_ready_i = 1'b1;
        tick();
        result_ready_i = 1'b0;
        #1;
        checks++;
        if (result_valid_o !== 1'b0) begin
            failures++; $display("FAIL basic_result_clear got=%0b exp=0", result_valid_o);
        end
        tick();
        $display("test_basic done");
    endtask

    task automatic test_reject();
        issue_valid_i = 1'b1; issue_req_instr_i = 32'h0000_0033; issue_req_id_i = 4'd5;
        issue_req_rs_valid_i = 2'b00;
        #1;
        checks++;
        if ({issue_ready_o, issue_resp_accept_o, issue_resp_writeback_o} !== 3'b100) begin
            failures++;
            $display("FAIL reject_resp got ready=%0b acc=%0b wb=%0b exp 1 0 0", issue_ready_o, issue_resp_accept_o, issue_resp_writeback_o);
        end
        tick();
        issue_valid_i = 1'b0; issue_req_rs_valid_i = 2'b11;
        commit_valid_i = 1'b1; commit_id_i = 4'd5; exe_ready_i = 1'b1;
        tick();
        commit_valid_i = 1'b0;
        for (int n = 0; n < 4; n++) begin
            #1;
            checks++;
            if (exe_valid_o !== 1'b0) begin
                failures++; $display("FAIL reject_no_exe cycle=%0d got=%0b exp=0", n, exe_valid_o);
            end
            tick();
        end
        exe_ready_i = 1'b0;
        $display("test_reject done");
    endtask

    task automatic test_commit_order();
        logic [31:0]      ins [4];
        logic [1:0][31:0] rsv [4];
        logic [31:0]      data;
        bit               found;
        for (int i = 0; i < 4; i++) begin
            ins[i] = mk_instr(7'h0B, 5'(i + 1), 3'(i), 7'($urandom));
            rsv[i] = {$urandom, $urandom};
            issue_one(ins[i], 4'(i), rsv[i], 1'b0);
        end
        issue_valid_i = 1'b1; issue_req_instr_i = mk_instr(7'h0B, 5'd9, 3'd0, 7'd0); issue_req_id_i = 4'd4;
        #1;
        checks++;
        if (issue_ready_o !== 1'b0) begin
            failures++; $display("FAIL full_ready got=%0b exp=0", issue_ready_o);
        end
        tick();
        issue_valid_i = 1'b0;
        commit_valid_i = 1'b1; commit_id_i = 4'd1; commit_kill_i = 1'b0;
        tick();
        commit_valid_i = 1'b0;
        for (int n = 0; n < 3; n++) begin
            #1;
            checks++;
            if (exe_valid_o !== 1'b0) begin
                failures++; $display("FAIL head_blocks cycle=%0d got exe_valid=%0b exp=0", n, exe_valid_o);
            end
            tick();
        end
        commit_valid_i = 1'b1; commit_id_i = 4'd0; commit_kill_i = 1'b1;
        tick();
        commit_valid_i = 1'b0; commit_kill_i = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 5; n++) begin
            #1;
            if (exe_valid_o === 1'b1) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!found) begin
            failures++; $display("FAIL kill_then_exe timeout exe_valid=%0b exp=1", exe_valid_o);
        end else if (exe_op_o !== {ins[1][31:25], ins[1][14:12]} || exe_rs_o !== rsv[1]) begin
            failures++;
            $display("FAIL kill_then_exe_fields got op=%h rs=%h exp op=%h rs=%h", exe_op_o, exe_rs_o,
                     {ins[1][31:25], ins[1][14:12]}, rsv[1]);
        end
        exe_ready_i = 1'b1;
        tick();
        exe_ready_i = 1'b0;
        data = $urandom;
        exe_done_i = 1'b1; exe_data_i = data;
        tick();
        exe_done_i = 1'b0;
        #1;
        checks++;
        if ({result_valid_o, result_id_o, result_rd_o, result_we_o, result_data_o} !== {1'b1, 4'd1, 5'd2, 1'b1, data}) begin
            failures++;
            $display("FAIL order_result got valid=%0b id=%0d rd=%0d we=%0b data=%h exp 1 1 2 1 %h",
                     result_valid_o, result_id_o, result_rd_o, result_we_o, result_data_o, data);
        end
        result_ready_i = 1'b1;
        tick();
        result_ready_i = 1'b0;
        for (int i = 2; i < 4; i++) begin
            commit_valid_i = 1'b1; commit_id_i = 4'(i); commit_kill_i = 1'b1;
            tick();
        end
        commit_valid_i = 1'b0; commit_kill_i = 1'b0;
        tick(); tick(); tick();
        $display("test_commit_order done");
    endtask

    task automatic test_ignored_commit();
        issue_valid_i = 1'b1; issue_req_instr_i = mk_instr(7'h0B, 5'd4, 3'd1, 7'd2); issue_req_id_i = 4'd7;
        issue_req_rs_valid_i = 2'b01;
        commit_valid_i = 1'b1; commit_id_i = 4'd7; commit_kill_i = 1'b0;
        #1;
        checks++;
        if (issue_ready_o !== 1'b0) begin
            failures++; $display("FAIL ignored_ready got=%0b exp=0", issue_ready_o);
        end
        tick();
        commit_valid_i = 1'b0; issue_valid_i = 1'b0;
        tick();
        issue_one(mk_instr(7'h0B, 5'd4, 3'd1, 7'd2), 4'd7, {$urandom, $urandom}, 1'b0);
        exe_ready_i = 1'b1;
        for (int n = 0; n < 5; n++) begin
            #1;
            checks++;
            if (exe_valid_o !== 1'b0) begin
                failures++; $display("FAIL not_precommitted cycle=%0d got exe_valid=%0b exp=0", n, exe_valid_o);
            end
            tick();
        end
        exe_ready_i = 1'b0;
        commit_valid_i = 1'b1; commit_id_i = 4'd7; commit_kill_i = 1'b1;
        tick();
        commit_valid_i = 1'b0; commit_kill_i = 1'b0;
        tick(); tick();
        $display("test_ignored_commit done");
    endtask

    task automatic test_backpressure();
        logic [31:0] data_a;
        logic [31:0] data_b;
        data_a = $urandom;
        data_b = $urandom;
        issue_one(mk_instr(7'h0B, 5'd5, 3'd3, 7'd1), 4'd8, {$urandom, $urandom}, 1'b1);
        exe_ready_i = 1'b1;
        issue_one(mk_instr(7'h0B, 5'd0, 3'd4, 7'd1), 4'd9, {$urandom, $urandom}, 1'b1);
        exe_ready_i = 1'b0;
        tick();
        exe_done_i = 1'b1; exe_data_i = data_a;
        tick();
        exe_done_i = 1'b0;
        for (int n = 0; n < 5; n++) begin
            #1;
            checks++;
            if ({result_valid_o, result_id_o, result_rd_o, result_we_o, result_data_o} !== {1'b1, 4'd8, 5'd5, 1'b1, data_a}
                || exe_valid_o !== 1'b0) begin
                failures++;
                $display("FAIL result_hold cycle=%0d got valid=%0b id=%0d rd=%0d we=%0b data=%h exe_valid=%0b exp 1 8 5 1 %h 0",
                         n, result_valid_o, result_id_o, result_rd_o, result_we_o, result_data_o, exe_valid_o, data_a);
            end
            tick();
        end
        result_ready_i = 1'b1;
        tick();
        result_ready_i = 1'b0;
        #1;
        checks++;
        if (result_valid_o !== 1'b0 || exe_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL result_release got result_valid=%0b exe_valid=%0b exp 0 1", result_valid_o, exe_valid_o);
        end
        exe_ready_i = 1'b1;
        tick();
        exe_ready_i = 1'b0;
        exe_done_i = 1'b1; exe_data_i = data_b;
        tick();
        exe_done_i = 1'b0;
        #1;
        checks++;
        if ({result_valid_o, result_id_o, result_rd_o, result_we_o, result_data_o} !== {1'b1, 4'd9, 5'd0, 1'b0, data_b}) begin
            failures++;
            $display("FAIL no_wb_result got valid=%0b id=%0d rd=%0d we=%0b data=%h exp 1 9 0 0 %h",
                     result_valid_o, result_id_o, result_rd_o, result_we_o, result_data_o, data_b);
        end
        result_ready_i = 1'b1;
        tick();
        result_ready_i = 1'b0;
        $display("test_backpressure done");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++)
            issue_one(mk_instr(7'h0B, 5'(i + 10), 3'd0, 7'd0), 4'(i + 10), {$urandom, $urandom}, 1'b1);
        exe_ready_i = 1'b1;
        tick();
        exe_ready_i = 1'b0;
        rst_i = 1'b1;
        #1;
        checks++;
        if (exe_valid_o !== 1'b0 || result_valid_o !== 1'b0) begin
            failures++; $display("FAIL reset_mid_async got exe_valid=%0b result_valid=%0b exp 0 0", exe_valid_o, result_valid_o);
        end
        tick();
        rst_i = 1'b0;
        exe_ready_i = 1'b1;
        exe_done_i = 1'b1;
        tick();
        exe_done_i = 1'b0;
        for (int n = 0; n < 4; n++) begin
            #1;
            checks++;
            if (exe_valid_o !== 1'b0 || result_valid_o !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid_dropped cycle=%0d got exe_valid=%0b result_valid=%0b exp 0 0", n, exe_valid_o, result_valid_o);
            end
            tick();
        end
        exe_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) issue_one(mk_instr(7'h0B, 5'd1, 3'd0, 7'd0), 4'(i), {$urandom, $urandom}, 1'b0);
        issue_valid_i = 1'b1; issue_req_instr_i = mk_instr(7'h0B, 5'd1, 3'd0, 7'd0); issue_req_id_i = 4'd4;
        #1;
        checks++;
        if (issue_ready_o !== 1'b0) begin
            failures++; $display("FAIL reset_mid_capacity got ready=%0b exp=0", issue_ready_o);
        end
        issue_valid_i = 1'b0;
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        item_t       pend[$];
        res_t        exp_res[$];
        int          und[$];
        item_t       it;
        res_t        er;
        logic [3:0]  next_id;
        logic [31:0] ins;
        logic [41:0] held;
        logic [3:0]  bogus;
        bit          busy, hold, draining, acc, used;
        int          cnt, cyc, r, k, n_results;
        logic [31:0] busy_data;
        do_reset();
        next_id = '0; busy = 0; hold = 0; draining = 0; cnt = 0; cyc = 0; n_results = 0;
        busy_data = '0; held = '0;
        while (1) begin
            if (cyc >= 3000) draining = 1;
            while (pend.size() > 0 && pend[0].decided && pend[0].kill) void'(pend.pop_front());
            if (draining && pend.size() == 0 && exp_res.size() == 0 && !busy && !result_valid_o) break;
            if (cyc >= 8000) begin
                checks++; failures++;
                $display("FAIL random_drain timeout pending=%0d results_left=%0d", pend.size(), exp_res.size());
                break;
            end
            exe_done_i = 1'b0;
            if (busy) begin
                cnt--;
                if (cnt == 0) begin
                    exe_done_i = 1'b1; exe_data_i = busy_data; busy = 0;
                end
            end
            result_ready_i = ($urandom % 10) < 7;
            exe_ready_i    = ($urandom % 10) < 6;
            ins = $urandom;
            if ($urandom % 5 != 0) ins[6:0] = 7'h0B;
            issue_req_instr_i    = ins;
            issue_req_id_i       = next_id;
            issue_req_rs_i       = {$urandom, $urandom};
            issue_req_rs_valid_i = ($urandom % 6 == 0) ? 2'($urandom) : 2'b11;
            issue_valid_i        = !draining && ($urandom % 2 == 0);
            commit_valid_i       = 1'b0;
            commit_kill_i        = 1'b0;
            #1;
            acc = (ins[6:0] == 7'h0B);
            if (issue_valid_i) begin
                if (!acc || issue_req_rs_valid_i != 2'b11) begin
                    checks++;
                    if (issue_ready_o !== !acc) begin
                        failures++;
                        $display("FAIL rand_ready instr=%h rs_valid=%b got=%0b exp=%0b", ins, issue_req_rs_valid_i, issue_ready_o, !acc);
                    end
                end
                if (issue_ready_o) begin
                    checks++;
                    if ({issue_resp_accept_o, issue_resp_writeback_o, issue_resp_dualread_o, issue_resp_loadstore_o}
                        !== {acc, acc && (ins[11:7] != 5'd0), 2'b00}) begin
                        failures++;
                        $display("FAIL rand_resp instr=%h got acc=%0b wb=%0b dr=%0b ls=%0b exp acc=%0b wb=%0b",
                                 ins, issue_resp_accept_o, issue_resp_writeback_o, issue_resp_dualread_o,
                                 issue_resp_loadstore_o, acc, acc && (ins[11:7] != 5'd0));
                    end
                    if (acc) begin
                        it.id = next_id; it.rd = ins[11:7]; it.we = (ins[11:7] != 5'd0);
                        it.op = {ins[31:25], ins[14:12]}; it.rs = issue_req_rs_i;
                        it.decided = 0; it.kill = 0;
                        pend.push_back(it);
                    end
                    next_id = next_id + 4'd1;
                end
            end
            und.delete();
            foreach (pend[j]) if (!pend[j].decided) und.push_back(j);
            r = $urandom % 100;
            if (und.size() > 0 && r < 35) begin
                k = und[$urandom % und.size()];
                commit_valid_i = 1'b1; commit_id_i = pend[k].id; commit_kill_i = ($urandom % 4 == 0);
                pend[k].decided = 1; pend[k].kill = commit_kill_i;
            end else if (r < 40) begin
                bogus = 4'($urandom); used = 0;
                foreach (pend[j]) if (pend[j].id == bogus) used = 1;
                if (!used) begin
                    commit_valid_i = 1'b1; commit_id_i = bogus; commit_kill_i = 1'($urandom);
                end
            end else if (r < 45) begin
                foreach (pend[j]) if (pend[j].decided && !pend[j].kill && !commit_valid_i) begin
                    commit_valid_i = 1'b1; commit_id_i = pend[j].id; commit_kill_i = 1'b0;
                end
            end
            if (exe_valid_o && exe_ready_i) begin
                checks++;
                while (pend.size() > 0 && pend[0].decided && pend[0].kill) void'(pend.pop_front());
                if (busy) begin
                    failures++; $display("FAIL rand_exe_while_busy cycle=%0d", cyc);
                end else if (pend.size() == 0 || !pend[0].decided) begin
                    failures++; $display("FAIL rand_exe_unexpected cycle=%0d pending=%0d", cyc, pend.size());
                end else if (exe_op_o !== pend[0].op || exe_rs_o !== pend[0].rs) begin
                    failures++;
                    $display("FAIL rand_exe_fields id=%0d got op=%h rs=%h exp op=%h rs=%h",
                             pend[0].id, exe_op_o, exe_rs_o, pend[0].op, pend[0].rs);
                    void'(pend.pop_front());
                end else begin
                    er.id = pend[0].id; er.rd = pend[0].rd; er.we = pend[0].we;
                    er.data = exe_model(pend[0].op, pend[0].rs);
                    exp_res.push_back(er);
                    busy = 1; cnt = $urandom_range(1, 3); busy_data = er.data;
                    void'(pend.pop_front());
                end
            end
            if (result_valid_o) begin
                if (hold) begin
                    checks++;
                    if ({result_id_o, result_rd_o, result_we_o, result_data_o} !== held) begin
                        failures++;
                        $display("FAIL rand_result_stable got=%h exp=%h", {result_id_o, result_rd_o, result_we_o, result_data_o}, held);
                    end
                end
                if (result_ready_i) begin
                    checks++; n_results++;
                    if (exp_res.size() == 0) begin
                        failures++; $display("FAIL rand_result_unexpected id=%0d", result_id_o);
                    end else begin
                        er = exp_res.pop_front();
                        if ({result_id_o, result_rd_o, result_we_o, result_data_o} !== {er.id, er.rd, er.we, er.data}) begin
                            failures++;
                            $display("FAIL rand_result got id=%0d rd=%0d we=%0b data=%h exp id=%0d rd=%0d we=%0b data=%h",
                                     result_id_o, result_rd_o, result_we_o, result_data_o, er.id, er.rd, er.we, er.data);
                        end
                    end
                    hold = 0;
                end else begin
                    hold = 1;
                    held = {result_id_o, result_rd_o, result_we_o, result_data_o};
                end
            end else begin
                hold = 0;
            end
            tick();
            cyc++;
        end
        checks++;
        if (n_results < 20) begin
            failures++; $display("FAIL rand_result_count got=%0d exp>=20", n_results);
        end
        idle_inputs();
        $display("test_random done results=%0d cycles=%0d", n_results, cyc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_reject();
        test_commit_order();
        test_ignored_commit();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
